// File: rtl/count_uart_reporter_if.sv
// ============================================================================
// Module      : count_uart_reporter_if
// Description : Counter-value and UART report signals between a counter
//               domain and the count_uart_reporter block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface count_uart_reporter_if;
    logic [7:0] count;
    logic       send_req;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (
        output count,
        output send_req,
        input  tx,
        input  busy,
        input  done
    );

    modport slave (
        input  count,
        input  send_req,
        output tx,
        output busy,
        output done
    );
endinterface

`default_nettype wire

// File: rtl/count_uart_reporter.sv
// ============================================================================
// Module      : count_uart_reporter
// Description : Reports an 8-bit counter value over UART (8N1) as a frame of
//               two uppercase hex digits followed by CR LF.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_uart_reporter #(
    parameter int CLKS_PER_BIT = 87,
    parameter bit AUTO_SEND    = 1'b1
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    count_uart_reporter_if.slave bus
);

    localparam int                  c_baud_w   = $clog2(CLKS_PER_BIT);
    localparam logic [c_baud_w-1:0] c_baud_max = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [c_baud_w-1:0] c_baud_one = c_baud_w'(1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_start = 2'd1;
    localparam logic [1:0] c_data  = 2'd2;
    localparam logic [1:0] c_stop  = 2'd3;

    logic [1:0]          r_state,    w_state_n;
    logic [c_baud_w-1:0] r_baud,     w_baud_n;
    logic [2:0]          r_bit_idx,  w_bit_idx_n;
    logic [1:0]          r_char_idx, w_char_idx_n;
    logic [7:0]          r_snap,     w_snap_n;
    logic [7:0]          r_last_sent, w_last_sent_n;
    logic                r_pending,  w_pending_n;
    logic                r_busy,     w_busy_n;
    logic                r_done,     w_done_n;
    logic                r_tx,       w_tx_n;
    logic                w_trig;
    logic [7:0]          w_char_n;

    function automatic logic [7:0] f_hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
    endfunction

    function automatic logic [7:0] f_char(input logic [7:0] snap, input logic [1:0] idx);
        case (idx)
            2'd0:    return f_hex(snap[7:4]);
            2'd1:    return f_hex(snap[3:0]);
            2'd2:    return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_idle;
            r_baud      <= '0;
            r_bit_idx   <= '0;
            r_char_idx  <= '0;
            r_snap      <= '0;
            r_last_sent <= '0;
            r_pending   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_tx        <= 1'b1;
        end else begin
            r_state     <= w_state_n;
            r_baud      <= w_baud_n;
            r_bit_idx   <= w_bit_idx_n;
            r_char_idx  <= w_char_idx_n;
            r_snap      <= w_snap_n;
            r_last_sent <= w_last_sent_n;
            r_pending   <= w_pending_n;
            r_busy      <= w_busy_n;
            r_done      <= w_done_n;
            r_tx        <= w_tx_n;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_baud_n      = r_baud;
        w_bit_idx_n   = r_bit_idx;
        w_char_idx_n  = r_char_idx;
        w_snap_n      = r_snap;
        w_last_sent_n = r_last_sent;
        w_pending_n   = r_pending;
        w_busy_n      = r_busy;
        w_done_n      = 1'b0;
        w_trig        = r_pending | bus.send_req | (AUTO_SEND & (bus.count != r_last_sent));

        if (r_state == c_idle) begin
            if (w_trig) begin
                w_snap_n      = bus.count;
                w_last_sent_n = bus.count;
                w_pending_n   = 1'b0;
                w_busy_n      = 1'b1;
                w_state_n     = c_start;
                w_baud_n      = c_baud_max;
                w_bit_idx_n   = 3'd0;
                w_char_idx_n  = 2'd0;
            end
        end else begin
            // Requests arriving mid-frame collapse into one pending report
            if (bus.send_req) begin
                w_pending_n = 1'b1;
            end
            if (r_baud == '0) begin
                w_baud_n = c_baud_max;
                case (r_state)
                    c_start: begin
                        w_state_n   = c_data;
                        w_bit_idx_n = 3'd0;
                    end
                    c_data: begin
                        if (r_bit_idx == 3'd7) begin
                            w_state_n = c_stop;
                        end else begin
                            w_bit_idx_n = r_bit_idx + 3'd1;
                        end
                    end
                    default: begin
                        if (r_char_idx == 2'd3) begin
                            w_state_n = c_idle;
                            w_busy_n  = 1'b0;
                            w_done_n  = 1'b1;
                        end else begin
                            w_char_idx_n = r_char_idx + 2'd1;
                            w_state_n    = c_start;
                        end
                    end
                endcase
            end else begin
                w_baud_n = r_baud - c_baud_one;
            end
        end

        // tx is registered from the next state so the line never glitches
        w_char_n = f_char(w_snap_n, w_char_idx_n);
        case (w_state_n)
            c_start: w_tx_n = 1'b0;
            c_data:  w_tx_n = w_char_n[w_bit_idx_n];
            default: w_tx_n = 1'b1;
        endcase
    end

    assign bus.tx   = r_tx;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_count_uart_reporter.sv
// ============================================================================
// Module      : tb_count_uart_reporter
// Description : Self-checking bench for count_uart_reporter with a
//               cycle-level reference model and a UART byte decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_count_uart_reporter;

    localparam int CPB   = 4;
    localparam int CHARW = 10 * CPB;
    localparam int FRAME = 4 * CHARW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    count_uart_reporter_if bus_a ();
    count_uart_reporter_if bus_b ();

    count_uart_reporter #(.CLKS_PER_BIT(CPB), .AUTO_SEND(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    count_uart_reporter #(.CLKS_PER_BIT(CPB), .AUTO_SEND(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    logic [7:0] cnt_v  [2];
    logic       req_v  [2];
    logic       tx_v   [2];
    logic       busy_v [2];
    logic       done_v [2];
    assign cnt_v[0]  = bus_a.count;    assign cnt_v[1]  = bus_b.count;
    assign req_v[0]  = bus_a.send_req; assign req_v[1]  = bus_b.send_req;
    assign tx_v[0]   = bus_a.tx;       assign tx_v[1]   = bus_b.tx;
    assign busy_v[0] = bus_a.busy;     assign busy_v[1] = bus_b.busy;
    assign done_v[0] = bus_a.done;     assign done_v[1] = bus_b.done;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(55 + n);
    endfunction

    // Reference model: a frame started in cycle T occupies T+1..T+FRAME, done at T+FRAME+1
    int         cyc_n = 0;
    logic [7:0] m_last [2];
    logic       m_pend [2];
    logic       m_act  [2];
    int         m_trig [2];
    logic [7:0] m_fb   [2][4];

    initial begin
        for (int u = 0; u < 2; u++) begin
            m_last[u] = 8'h00; m_pend[u] = 1'b0; m_act[u] = 1'b0; m_trig[u] = 0;
        end
    end

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin : g_model
            int   k;
            int   bp;
            logic etx, ebusy, edone, idle;
            if (!rst_n) begin
                m_last[u] = 8'h00; m_pend[u] = 1'b0; m_act[u] = 1'b0;
            end
            etx = 1'b1; ebusy = 1'b0; edone = 1'b0;
            k = cyc_n - m_trig[u] - 1;
            if (m_act[u] && k >= 0 && k < FRAME) begin
                ebusy = 1'b1;
                bp    = (k % CHARW) / CPB;
                etx   = (bp == 0) ? 1'b0 : (bp == 9) ? 1'b1 : m_fb[u][k / CHARW][bp - 1];
            end else if (m_act[u] && k == FRAME) begin
                edone = 1'b1;
            end
            check_eq(u == 0 ? "tx_a"   : "tx_b",   {31'd0, tx_v[u]},   {31'd0, etx});
            check_eq(u == 0 ? "busy_a" : "busy_b", {31'd0, busy_v[u]}, {31'd0, ebusy});
            check_eq(u == 0 ? "done_a" : "done_b", {31'd0, done_v[u]}, {31'd0, edone});
            idle = !m_act[u] || (k >= FRAME);
            if (rst_n && idle) begin
                if (m_pend[u] || req_v[u] || (u == 0 && cnt_v[u] != m_last[u])) begin
                    m_trig[u]  = cyc_n;
                    m_act[u]   = 1'b1;
                    m_last[u]  = cnt_v[u];
                    m_pend[u]  = 1'b0;
                    m_fb[u][0] = hexc(int'(cnt_v[u][7:4]));
                    m_fb[u][1] = hexc(int'(cnt_v[u][3:0]));
                    m_fb[u][2] = 8'h0D;
                    m_fb[u][3] = 8'h0A;
                end
            end else if (rst_n && req_v[u]) begin
                m_pend[u] = 1'b1;
            end
        end
        cyc_n++;
    end

    // UART decoder, samples each bit at its centre
    logic       rx_on  [2];
    int         rx_cnt [2];
    logic [7:0] rx_sh  [2];
    logic [7:0] rxq0 [$];
    logic [7:0] rxq1 [$];

    initial begin
        rx_on[0] = 1'b0; rx_on[1] = 1'b0; rx_cnt[0] = 0; rx_cnt[1] = 0;
    end

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin : g_rx
            if (!rst_n) begin
                rx_on[u] = 1'b0;
            end else if (!rx_on[u]) begin
                if (tx_v[u] == 1'b0) begin
                    rx_on[u]  = 1'b1;
                    rx_cnt[u] = 0;
                end
            end else begin
                rx_cnt[u]++;
                if (rx_cnt[u] < 9 * CPB && rx_cnt[u] >= CPB && (rx_cnt[u] % CPB) == CPB / 2)
                    rx_sh[u][rx_cnt[u] / CPB - 1] = tx_v[u];
                if (rx_cnt[u] == 9 * CPB + CPB / 2) begin
                    if (u == 0) rxq0.push_back(rx_sh[0]);
                    else        rxq1.push_back(rx_sh[1]);
                    rx_on[u] = 1'b0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int u, input int lim, input string tag);
        int i;
        i = 0;
        tick(1);
        while (!done_v[u] && i < lim) begin
            tick(1);
            i++;
        end
        check_eq(tag, {31'd0, done_v[u]}, 32'd1);
    endtask

    task automatic check_frame(input string tag, input int u, input logic [31:0] exp4);
        logic [15:0] got;
        for (int i = 0; i < 4; i++) begin
            if (u == 0) got = (rxq0.size() > 0) ? {8'd0, rxq0.pop_front()} : 16'hFFFF;
            else        got = (rxq1.size() > 0) ? {8'd0, rxq1.pop_front()} : 16'hFFFF;
            check_eq($sformatf("%s byte%0d", tag, i), {16'd0, got}, {24'd0, exp4[31 - 8 * i -: 8]});
        end
    endtask

    task automatic pulse_req(input int u);
        if (u == 0) bus_a.send_req = 1'b1; else bus_b.send_req = 1'b1;
        tick(1);
        if (u == 0) bus_a.send_req = 1'b0; else bus_b.send_req = 1'b0;
    endtask

    initial begin
        int i;
        bus_a.count = 8'h00; bus_a.send_req = 1'b0;
        bus_b.count = 8'h00; bus_b.send_req = 1'b0;
        tick(3);
        check_eq("reset tx",   {31'd0, bus_a.tx},   32'd1);
        check_eq("reset busy", {31'd0, bus_a.busy}, 32'd0);
        check_eq("reset done", {31'd0, bus_a.done}, 32'd0);
        rst_n = 1'b1;
        tick(20);
        check_eq("zero count no frame", rxq0.size(), 32'd0);

        // Single auto report and frame length
        bus_a.count = 8'h3C;
        i = 0;
        while (bus_a.tx && i < 50) begin tick(1); i++; end
        check_eq("t1 tx fall", {31'd0, bus_a.tx}, 32'd0);
        i = 0;
        while (!bus_a.done && i < 400) begin tick(1); i++; end
        check_eq("t1 frame length", i, FRAME);
        tick(1);
        check_eq("t1 busy after done", {31'd0, bus_a.busy}, 32'd0);
        check_frame("t1", 0, 32'h33430D0A);

        // Two back-to-back values
        bus_a.count = 8'hFF;
        wait_done(0, 400, "t2a done");
        bus_a.count = 8'h0A;
        wait_done(0, 400, "t2b done");
        check_frame("t2a", 0, 32'h46460D0A);
        check_frame("t2b", 0, 32'h30410D0A);

        // Changes and requests during a frame collapse into one follow-up
        bus_a.count = 8'h11;
        tick(5);
        check_eq("t3 busy", {31'd0, bus_a.busy}, 32'd1);
        bus_a.count = 8'h12;
        tick(3);
        pulse_req(0);
        tick(10);
        bus_a.count = 8'h13;
        tick(2);
        pulse_req(0);
        wait_done(0, 400, "t3a done");
        wait_done(0, 400, "t3b done");
        check_frame("t3a", 0, 32'h31310D0A);
        check_frame("t3b", 0, 32'h31330D0A);
        tick(200);
        check_eq("t3 no extra frame", rxq0.size(), 32'd0);

        // Manual-only instance
        bus_b.count = 8'h55;
        tick(200);
        check_eq("t4 no auto frame", rxq1.size(), 32'd0);
        pulse_req(1);
        wait_done(1, 400, "t4 done");
        check_frame("t4", 1, 32'h35350D0A);

        // Asynchronous reset during char 1 data bits
        bus_a.count = 8'h77;
        i = 0;
        while (bus_a.tx && i < 50) begin tick(1); i++; end
        tick(50);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5 async tx",   {31'd0, bus_a.tx},   32'd1);
        check_eq("t5 async busy", {31'd0, bus_a.busy}, 32'd0);
        tick(3);
        bus_a.count = 8'h00;
        tick(1);
        rst_n = 1'b1;
        check_eq("t5 partial char", rxq0.size(), 32'd1);
        rxq0.delete();
        tick(200);
        check_eq("t5 no frame after reset", rxq0.size(), 32'd0);

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 39) == 0) bus_a.count = 8'($urandom);
            if ($urandom_range(0, 39) == 0) bus_b.count = 8'($urandom);
            bus_a.send_req = ($urandom_range(0, 59) == 0);
            bus_b.send_req = ($urandom_range(0, 59) == 0);
            tick(1);
        end
        bus_a.send_req = 1'b0;
        bus_b.send_req = 1'b0;
        tick(400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
